// File: rtl/executor_commit_clear_pkg.sv
// executor_commit_clear_pkg: shared Tetris types for the commit-and-clear stage.
// Contents: board/shape dimensions, point_t (window origin), shape_t (square
// shape window) and the commit_clear_state_e state encoding.
package tetris;
  localparam int board_width_lp = 16;
  localparam int board_height_lp = 32;
  localparam int shape_dim_lp = 4;
  typedef struct packed {
    logic [$clog2(board_width_lp)-1:0] x;
    logic [$clog2(board_height_lp)-1:0] y;
  } point_t;
  typedef logic [shape_dim_lp-1:0][shape_dim_lp-1:0] shape_t;
  // Nine states do not fit in three bits, so the encoding uses four.
  typedef enum logic [3:0] {
    eIDLE, eWrite, eWaitW, eSel, eRead, eCheck, eClear, eWaitC, eDone
  } commit_clear_state_e;
endpackage

// File: rtl/executor_commit_clear_row_full_check.sv
// row_full_check: detects a completely filled board row.
// Ports: clk_i/reset_i (async, active high), en_i captures the flag,
// row_i row data, full_o combinational all-ones, full_r_o flag captured on en_i.
module row_full_check #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] row_i,
  output logic               full_o,
  output logic               full_r_o
);
  logic r_full;
  assign full_o = &row_i;
  assign full_r_o = r_full;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_full <= 1'b0;
    else if (en_i) r_full <= full_o;
endmodule

// File: rtl/executor_commit_clear.sv
// executor_commit_clear: merges the active piece into the board, then scans and clears full rows.
// Ports: clk_i/reset_i (async, active high); v_i/done_o/empty_o controller handshake;
// pos_i, shape_i, shape_on_board_i piece and board window; lines_o lines cleared;
// mm_write_* block write, mm_row_* row read/clear, mm_is_ready_i memory idle.
// Macro EXECUTOR_COMMIT_SCORE_EN adds total_lines_o, a saturating 16-bit line total.
module executor_commit_clear
  import tetris::*;
#(
  parameter int width_p = 16,
  parameter int height_p = 32,
  parameter int shape_dim_p = 4
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      v_i,
  output logic                                      done_o,
  input  point_t                                    pos_i,
  input  logic [shape_dim_p-1:0][shape_dim_p-1:0]   shape_i,
  input  logic [shape_dim_p-1:0][shape_dim_p-1:0]   shape_on_board_i,
  output logic                                      empty_o,
`ifdef EXECUTOR_COMMIT_SCORE_EN
  output logic [15:0]                               total_lines_o,
`endif
  output logic [$clog2(shape_dim_p+1)-1:0]          lines_o,
  output point_t                                    mm_write_addr_o,
  output logic [shape_dim_p-1:0][shape_dim_p-1:0]   mm_write_data_o,
  output logic                                      mm_write_v_o,
  output logic [$clog2(height_p)-1:0]               mm_row_addr_o,
  output logic                                      mm_row_read_v_o,
  input  logic [width_p-1:0]                        mm_row_i,
  output logic                                      mm_row_clear_v_o,
  input  logic                                      mm_is_ready_i
);
  localparam int aw_lp = $clog2(height_p);
  localparam int rw_lp = aw_lp + 1;
  localparam int lw_lp = $clog2(shape_dim_p + 1);
  localparam int iw_lp = $clog2(shape_dim_p);
  commit_clear_state_e r_state;
  point_t r_pos;
  logic [shape_dim_p-1:0][shape_dim_p-1:0] r_shape;
  logic [lw_lp-1:0] r_i, r_lines;
  logic [rw_lp-1:0] w_row;
  logic w_last, w_skip, w_full, w_full_r;
  // Row index carries one extra bit so rows past the bottom never wrap to the top.
  assign w_row = rw_lp'(r_pos.y) + rw_lp'(r_i);
  assign w_last = r_i == lw_lp'(shape_dim_p);
  assign w_skip = (w_row >= rw_lp'(height_p)) || (r_shape[r_i[iw_lp-1:0]] == '0);
  row_full_check #(.width_p(width_p)) u_full (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (r_state == eCheck),
    .row_i   (mm_row_i),
    .full_o  (w_full),
    .full_r_o(w_full_r)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_state <= eIDLE;
      r_pos <= '0;
      r_shape <= '0;
      r_i <= '0;
      r_lines <= '0;
    end else begin
      case (r_state)
        eIDLE: if (v_i) begin
          r_state <= eWrite;
          r_pos <= pos_i;
          r_shape <= shape_i | shape_on_board_i;
          r_i <= '0;
          r_lines <= '0;
        end
        eWrite: r_state <= eWaitW;
        eWaitW: if (mm_is_ready_i) r_state <= eSel;
        eSel: if (w_last) r_state <= eDone;
          else if (w_skip) r_i <= r_i + lw_lp'(1);
          else r_state <= eRead;
        eRead: r_state <= eCheck;
        eCheck: if (w_full) r_state <= eClear;
          else begin
            r_i <= r_i + lw_lp'(1);
            r_state <= eSel;
          end
        eClear: begin
          r_lines <= r_lines + lw_lp'(w_full_r);
          r_state <= eWaitC;
        end
        eWaitC: if (mm_is_ready_i) begin
          r_i <= r_i + lw_lp'(1);
          r_state <= eSel;
        end
        eDone: r_state <= eIDLE;
        default: r_state <= eIDLE;
      endcase
    end
`ifdef EXECUTOR_COMMIT_SCORE_EN
  logic [15:0] r_total;
  logic [16:0] w_sum;
  assign w_sum = {1'b0, r_total} + 17'(r_lines);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_total <= '0;
    else if (r_state == eDone) r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  assign total_lines_o = r_total;
`endif
  assign done_o = r_state == eDone;
  assign empty_o = r_state == eDone;
  assign lines_o = r_lines;
  assign mm_write_addr_o = r_pos;
  assign mm_write_data_o = r_shape;
  assign mm_write_v_o = r_state == eWrite;
  assign mm_row_addr_o = w_row[aw_lp-1:0];
  assign mm_row_read_v_o = r_state == eRead;
  // The captured flag gates the clear so a row is only deleted if it was seen full.
  assign mm_row_clear_v_o = (r_state == eClear) && w_full_r;
endmodule

// File: tb/tb_executor_commit_clear.sv
// tb_executor_commit_clear: scoreboard bench with a board-memory model and a scenario reference model.
module tb_executor_commit_clear;
  import tetris::*;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic v_i = 1'b0;
  logic done_o, empty_o, mm_write_v_o, mm_row_read_v_o, mm_row_clear_v_o;
  logic mm_is_ready_i = 1'b1;
  point_t pos_i = '0;
  point_t mm_write_addr_o;
  logic [3:0][3:0] shape_i = '0;
  logic [3:0][3:0] shape_on_board_i = '0;
  logic [3:0][3:0] mm_write_data_o;
  logic [2:0] lines_o;
  logic [4:0] mm_row_addr_o;
  logic [15:0] mm_row_i = '0;
`ifdef EXECUTOR_COMMIT_SCORE_EN
  logic [15:0] total_lines_o;
  int tot_exp = 0;
`endif
  always #5 clk = ~clk;

  executor_commit_clear dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .done_o(done_o), .pos_i(pos_i),
    .shape_i(shape_i), .shape_on_board_i(shape_on_board_i), .empty_o(empty_o),
`ifdef EXECUTOR_COMMIT_SCORE_EN
    .total_lines_o(total_lines_o),
`endif
    .lines_o(lines_o), .mm_write_addr_o(mm_write_addr_o), .mm_write_data_o(mm_write_data_o),
    .mm_write_v_o(mm_write_v_o), .mm_row_addr_o(mm_row_addr_o), .mm_row_read_v_o(mm_row_read_v_o),
    .mm_row_i(mm_row_i), .mm_row_clear_v_o(mm_row_clear_v_o), .mm_is_ready_i(mm_is_ready_i)
  );

  // kind: 0 block write, 1 row read, 2 row clear, 3 done (addr = lines, data = empty_o)
  typedef struct {int kind; int addr; logic [15:0] data;} ev_t;
  ev_t exp_q[$];
  logic [15:0] board [32];
  int vectors = 0, miscompares = 0, busy = 0, stall = 0;
  bit saw_clear = 0;

  task automatic cmp(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic chk(input int k, input int a, input logic [15:0] d);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event unexpected kind=%0d addr=%0d data=%h, none required", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        miscompares++;
        $display("FAIL event got kind=%0d addr=%0d data=%h required kind=%0d addr=%0d data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Board cells under a shape window; column c is row bit 15-c.
  function automatic logic [15:0] under(input int x, input int y);
    logic [15:0] v = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (y + i < 32 && x + j < 16) v[4*i+j] = board[y+i][15-(x+j)];
    return v;
  endfunction

  // Reference: merge the piece, then walk touched rows top to bottom clearing full ones.
  task automatic expect_commit(input int x, input int y, input logic [15:0] m);
    logic [15:0] b [32];
    int lines = 0;
    b = board;
    exp_q.push_back('{0, x * 32 + y, m});
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (y + i < 32 && x + j < 16) b[y+i][15-(x+j)] = m[4*i+j];
    for (int i = 0; i < 4; i++) begin
      int r = y + i;
      if (r < 32 && m[4*i+:4] != 4'h0) begin
        exp_q.push_back('{1, r, 16'h0});
        if (b[r] == 16'hFFFF) begin
          exp_q.push_back('{2, r, 16'h0});
          lines++;
          for (int k = r; k > 0; k--) b[k] = b[k-1];
          b[0] = '0;
        end
      end
    end
    exp_q.push_back('{3, lines, 16'h1});
  endtask

  // Monitor plus matrix-memory model.
  always @(negedge clk) begin
    if (reset_i) begin
      busy = 0;
      mm_is_ready_i = 1'b1;
`ifdef EXECUTOR_COMMIT_SCORE_EN
      tot_exp = 0;
`endif
    end else begin
      if (mm_write_v_o) begin
        chk(0, int'(mm_write_addr_o), mm_write_data_o);
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            if (int'(mm_write_addr_o.y) + i < 32 && int'(mm_write_addr_o.x) + j < 16)
              board[int'(mm_write_addr_o.y)+i][15-(int'(mm_write_addr_o.x)+j)] = mm_write_data_o[i][j];
        busy = stall;
      end else if (mm_row_clear_v_o) begin
        chk(2, int'(mm_row_addr_o), 16'h0);
        saw_clear = 1;
        for (int k = int'(mm_row_addr_o); k > 0; k--) board[k] = board[k-1];
        board[0] = '0;
        busy = stall;
      end else if (busy > 0) busy--;
      if (mm_row_read_v_o) begin
        chk(1, int'(mm_row_addr_o), 16'h0);
        mm_row_i = board[mm_row_addr_o];
      end
      if (done_o) begin
        chk(3, int'(lines_o), {15'b0, empty_o});
`ifdef EXECUTOR_COMMIT_SCORE_EN
        cmp("total_lines", int'(total_lines_o), tot_exp);
        tot_exp = (tot_exp + int'(lines_o) > 65535) ? 65535 : tot_exp + int'(lines_o);
`endif
      end else if (empty_o) chk(4, 0, 16'h1);
      mm_is_ready_i = (busy == 0);
    end
  end

  task automatic run(input int x, input int y, input logic [15:0] sh);
    logic [15:0] onb;
    int n = 0;
    onb = under(x, y);
    expect_commit(x, y, sh | onb);
    @(negedge clk);
    pos_i.x = 4'(x);
    pos_i.y = 5'(y);
    shape_i = sh;
    shape_on_board_i = onb;
    v_i = 1'b1;
    @(negedge clk);
    v_i = 1'b0;
    while (!done_o && n < 400) begin
      v_i = 1'($urandom);
      pos_i = point_t'(9'($urandom));
      shape_i = 16'($urandom);
      shape_on_board_i = 16'($urandom);
      @(negedge clk);
      n++;
    end
    v_i = 1'b0;
    cmp("done_within_budget", int'(n < 400), 1);
    @(negedge clk);
    cmp("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [15:0] hole, onb;
    for (int r = 0; r < 32; r++) board[r] = '0;
    #12;
    cmp("rst_done", int'(done_o), 0);
    cmp("rst_empty", int'(empty_o), 0);
    cmp("rst_write_v", int'(mm_write_v_o), 0);
    cmp("rst_read_v", int'(mm_row_read_v_o), 0);
    cmp("rst_clear_v", int'(mm_row_clear_v_o), 0);
    cmp("rst_lines", int'(lines_o), 0);
    cmp("rst_write_addr", int'(mm_write_addr_o), 0);
    cmp("rst_write_data", int'(mm_write_data_o), 0);
    @(negedge clk);
    #2 reset_i = 1'b0;
    stall = 2;
    run(4, 10, 16'h7100);
    board[31] = 16'hFFF0;
    run(12, 31, 16'h000F);
    for (int r = 28; r < 32; r++) board[r] = 16'h7FFF;
    stall = 1;
    run(0, 28, 16'h1111);
`ifdef EXECUTOR_COMMIT_SCORE_EN
    cmp("total_after_two", int'(total_lines_o), 5);
`endif
    board[30] = '0;
    board[31] = '0;
    run(4, 30, 16'hFF00);
    stall = 5;
    board[31] = 16'hFFF0;
    run(12, 31, 16'h000F);
    board[31] = 16'hFFF0;
    onb = under(12, 31);
    expect_commit(12, 31, 16'h000F | onb);
    saw_clear = 0;
    @(negedge clk);
    pos_i.x = 4'd12;
    pos_i.y = 5'd31;
    shape_i = 16'h000F;
    shape_on_board_i = onb;
    v_i = 1'b1;
    @(negedge clk);
    v_i = 1'b0;
    n = 0;
    while (!saw_clear && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmp("clear_within_budget", int'(n < 100), 1);
    #2 reset_i = 1'b1;
    #1;
    cmp("async_lines", int'(lines_o), 0);
    cmp("async_done", int'(done_o), 0);
    cmp("async_clear_v", int'(mm_row_clear_v_o), 0);
    cmp("async_write_v", int'(mm_write_v_o), 0);
    cmp("async_read_v", int'(mm_row_read_v_o), 0);
`ifdef EXECUTOR_COMMIT_SCORE_EN
    cmp("async_total", int'(total_lines_o), 0);
`endif
    exp_q.delete();
    @(negedge clk);
    #2 reset_i = 1'b0;
    stall = 0;
    run(4, 10, 16'h7100);
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 32; r++) begin
        hole = 16'h1 << $urandom_range(0, 15);
        board[r] = ($urandom_range(0, 2) == 0) ? ~hole : 16'($urandom);
      end
      stall = $urandom_range(0, 3);
      run($urandom_range(0, 15), $urandom_range(0, 31), 16'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
